// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - LC-3b data-memory port initiator (load/store sequencing, byte steering, wait states)
module mem_access_unit #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        write,
    input  logic        byteOp,
    input  logic        sext,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        fault,
    output logic [15:0] rdata,
    output logic [15:0] memAddr,
    output logic        memEn,
    output logic        memWeLow,
    output logic        memWeHi,
    output logic [15:0] memDataIn,
    input  logic [15:0] memDataOut
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        l_write, l_byte, l_sext;
    logic [15:0] l_addr;
    logic [7:0]  sel_byte;

    logic        done_d, fault_d, mem_en_d, we_lo_d, we_hi_d;
    logic [15:0] rdata_d, mem_addr_d, mem_din_d;

    assign ready    = (state == S_IDLE) && !reset;
    assign sel_byte = l_addr[0] ? memDataOut[15:8] : memDataOut[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            l_write   <= 1'b0;
            l_byte    <= 1'b0;
            l_sext    <= 1'b0;
            l_addr    <= 16'h0000;
            done      <= 1'b0;
            fault     <= 1'b0;
            rdata     <= 16'h0000;
            memAddr   <= 16'h0000;
            memEn     <= 1'b0;
            memWeLow  <= 1'b0;
            memWeHi   <= 1'b0;
            memDataIn <= 16'h0000;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == S_IDLE && req) begin
                l_write <= write;
                l_byte  <= byteOp;
                l_sext  <= sext;
                l_addr  <= addr;
            end
            done      <= done_d;
            fault     <= fault_d;
            rdata     <= rdata_d;
            memAddr   <= mem_addr_d;
            memEn     <= mem_en_d;
            memWeLow  <= we_lo_d;
            memWeHi   <= we_hi_d;
            memDataIn <= mem_din_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_d = (!byteOp && addr[0]) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = WAIT_INIT;
                if (WAIT_CYCLES > 0) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = l_write ? S_DONE : S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = l_write ? S_DONE : S_CAPTURE;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered, so ISSUE drives from the live request operands.
    always_comb begin
        done_d     = (state_d == S_DONE);
        fault_d    = (state == S_IDLE) && (state_d == S_DONE);
        rdata_d    = 16'h0000;
        mem_en_d   = 1'b0;
        mem_addr_d = 16'h0000;
        we_lo_d    = 1'b0;
        we_hi_d    = 1'b0;
        mem_din_d  = 16'h0000;
        if (state == S_CAPTURE) begin
            rdata_d = l_byte ? {{8{l_sext & sel_byte[7]}}, sel_byte} : memDataOut;
        end
        if (state_d == S_ISSUE) begin
            mem_en_d   = 1'b1;
            mem_addr_d = addr;
            if (write) begin
                if (byteOp) begin
                    mem_din_d = {wdata[7:0], wdata[7:0]};
                    we_hi_d   = addr[0];
                    we_lo_d   = ~addr[0];
                end else begin
                    mem_din_d = wdata;
                    we_hi_d   = 1'b1;
                    we_lo_d   = 1'b1;
                end
            end
        end else if (state_d == S_WAIT) begin
            // Hold the read address so memory output stays valid; never repeat the write.
            mem_en_d   = 1'b1;
            mem_addr_d = l_addr;
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the LC-3b data-memory port: it turns a single MEM-stage load/store request into the address, enable and byte-write-enable sequence of the synchronous dual-port memory's read/write port (port 2). It handles byte-lane steering, odd-address word faults, byte extraction with sign or zero extension, and optional wait-state insertion. It sits between the pipeline MEM stage and memory port 2; port 1 (fetch) is untouched.

## Interface
- WAIT_CYCLES, 0: extra cycles the unit holds each access before completing; range 0–15.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- write  in  1  1 = store, 0 = load.
- byteOp  in  1  1 = byte access, 0 = word access.
- sext  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  16  byte address.
- wdata  in  16  store data; byte stores use wdata[7:0].
- ready  out  1  high in IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; 1 = unaligned word access.
- rdata  out  16  load result; valid with done.
- memAddr  out  16  to memory addr2.
- memEn  out  1  to memory en.
- memWeLow  out  1  to memory weLow.
- memWeHi  out  1  to memory weHi.
- memDataIn  out  16  to memory dataIn.
- memDataOut  in  16  from memory dataOut2.

## Operation
- All outputs except ready are registered. Reset values: state IDLE, done=0, fault=0, rdata=0, memAddr=0, memEn=0, memWeLow=0, memWeHi=0, memDataIn=0.
- ready = (state == IDLE) and not reset.
- IDLE: on req=1, latch write, byteOp, sext, addr and wdata.
  - If byteOp=0 and addr[0]=1: go to DONE with fault=1, rdata=0. No memory cycle is issued.
  - Otherwise go to ISSUE.
- ISSUE, one cycle:
  - memEn=1 and memAddr = latched addr.
  - Word store: memWeLow=memWeHi=1, memDataIn=wdata.
  - Byte store: memDataIn={wdata[7:0],wdata[7:0]}, memWeHi=addr[0], memWeLow=~addr[0].
  - Load: both write enables 0.
  - Next state is WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES−1). Otherwise CAPTURE for a load, DONE for a store.
- WAIT: memEn stays 1 with both write enables 0, so the memory output stays valid and no write repeats. The counter decrements. At 0, go to CAPTURE for a load or DONE for a store.
- CAPTURE (loads only): memEn=0. memDataOut carries data from the previous edge.
  - Word load: rdata = memDataOut.
  - Byte load: selected byte b = addr[0] ? memDataOut[15:8] : memDataOut[7:0]. rdata = {8{sext&b[7]}, b}.
  - Next state DONE.
- DONE: done=1 for exactly one cycle with fault/rdata valid. memEn and both write enables are 0. Next state IDLE.
- Stores complete with rdata=0, fault=0.
- The requester holds its operands until done and drops req in the done cycle. A req still high in the following IDLE cycle starts a new access.
- Memory outputs are deasserted (0) in IDLE, CAPTURE and DONE.

## Timing
- Request sampled at edge E0. Completion (done=1) arrives in the cycle after:
  - Load: E0+3 (+WAIT_CYCLES).
  - Store: E0+2 (+WAIT_CYCLES).
  - Fault: E0+1.
- The memory write commits at the edge ending ISSUE.
- Back-to-back: the earliest next req is sampled in the IDLE cycle after DONE. Throughput is one load per 4+WAIT_CYCLES cycles.
- Reset mid-operation: the next state is IDLE and all outputs take reset values at that edge. No done is issued.
  - A write whose ISSUE cycle coincides with reset still commits, because the memory samples the same edge.
- req is ignored outside IDLE.

## Test plan
- Word load: memory word 0x0100 = 0xABCD, req load word addr 0x0100 -> done 3 cycles after the req edge, rdata=0xABCD, fault=0, memEn high exactly one cycle.
- Signed byte load at odd address: word 0x0200 = 0x80CD, load byte sext=1 addr 0x0201 -> rdata=0xFF80. With sext=0 -> 0x0080. At addr 0x0200 with sext=1 -> 0xFFCD.
- Byte store: word 0x0300 = 0xABCD, store byte addr 0x0301 wdata 0x1234 -> ISSUE shows memWeHi=1, memWeLow=0, memDataIn=0x3434. A subsequent word load at 0x0300 returns 0x34CD.
- Unaligned word: load word addr 0x0401 -> done+fault one cycle after the req edge, rdata=0, memEn never asserted, memory unchanged.
- WAIT_CYCLES=2: word store 0xBEEF to 0x0500 -> memEn high 3 cycles, write enables high only in the first, done 4 cycles after the req edge. A load of 0x0500 then returns 0xBEEF, done 5 cycles after its req edge.
- Reset in CAPTURE of a load -> next cycle: state IDLE, ready=1, done never pulses, all mem outputs 0. A fresh load then completes normally.
